freq_lock_monitor: RTL and testbench
====================================

// Module: freq_lock_monitor
// PURPOSE
// - Downstream checker for the frequency multiplier. Measures each InFreq period in RefClk
//   cycles and counts OutFreq rising edges inside that period.
// - Flags lock when the edge count equals 2**n within +/-TOL.
// - Feeds the lab display/LED logic with lock status, measured period and edge count.
// - Starts measuring once the multiplier reports done (enable tied high after done).
// PARAMETERS
// - CNT_W  16  width of the RefClk period counter; saturates at 2**CNT_W-1
// - TOL     1  allowed |out_edges - 2**n| for lock, in edges
// PORTS
// - RefClk      in   1      system clock; all state is on its rising edge
// - rst         in   1      asynchronous, active-high reset
// - enable      in   1      measurement run; low forces IDLE
// - InFreq      in   1      reference input; async to RefClk
// - OutFreq     in   1      multiplier output; async to RefClk
// - n           in   3      multiplier exponent; expected factor = 2**n (1..128)
// - in_period   out  CNT_W  RefClk cycles in the last InFreq period
// - out_edges   out  9      OutFreq rising edges in the last InFreq period (saturating)
// - valid       out  1      1-cycle pulse: in_period/out_edges/locked updated
// - locked      out  1      last window matched 2**n within TOL
// - timeout     out  1      last window saturated the period counter
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; counters and synchronisers cleared.
// - InFreq and OutFreq each pass a 2-flop synchroniser plus a rising-edge detector:
//   edge pulse 3 RefClk cycles after the pin edge. Only the synchronised pulses are used.
// - n is sampled into a register on every window open; mid-window changes of n do not
//   affect the current window.
// - FSM states:
//   - IDLE: counters held at 0. enable=1 -> ARM.
//   - ARM: wait for InFreq edge pulse. On the pulse: period_cnt=1, edge_cnt=0,
//     latch n -> MEAS.
//   - MEAS: period_cnt increments every cycle. edge_cnt increments on each OutFreq pulse,
//     saturating at 511.
//     - InFreq pulse -> EVAL.
//     - If period_cnt reaches 2**CNT_W-1 with no InFreq pulse -> EVAL with timeout.
//   - EVAL (1 cycle): register in_period=period_cnt and out_edges=edge_cnt; pulse valid=1.
//     - locked = !timeout && |edge_cnt - (1<<n_lat)| <= TOL, computed at 10-bit signed width.
//     - timeout output = timeout flag.
//     - Next state: MEAS directly with period_cnt=1, edge_cnt=0, n relatched (back-to-back
//       windows share the closing/opening edge), but only if no timeout and enable=1.
//     - On timeout -> ARM. If enable=0 -> IDLE.
// - Simultaneous InFreq and OutFreq pulses in the closing cycle: the OutFreq edge counts in
//   the closing window, not the new one.
// - OutFreq pulse in the ARM-exit cycle is not counted.
// - enable falling in MEAS: abort to IDLE next cycle, no valid; outputs keep last values.
// - In IDLE/ARM, locked/in_period/out_edges/timeout hold their last EVAL values; only
//   reset clears them.
// - Async rst mid-window: immediate return to reset values; no valid is generated.
// - valid is never high two consecutive cycles; minimum spacing is one InFreq period.
// TESTING
// - Window and lock: RefClk 50 MHz, InFreq period 1000 cycles, OutFreq period 125, n=3,
//   enable=1 -> from the 2nd window on, in_period=1000, out_edges=8, locked=1, valid
//   once per 1000 cycles.
// - Tolerance: n=3 with OutFreq period 111 (9 edges) -> locked=1 at TOL=1.
//   OutFreq period 100 (10 edges) -> locked=0, out_edges=10.
// - Timeout: InFreq held low after ARM exit, CNT_W=8 -> valid with timeout=1, locked=0,
//   in_period=255 after 254 MEAS cycles; FSM back in ARM; next InFreq edge restarts.
// - Coincident edges: OutFreq edges aligned to InFreq edges, n=2 -> out_edges=4, not 5
//   or 3, every window.
// - Abort/reset: drop enable mid-window -> no valid, outputs unchanged.
//   Assert rst mid-window -> all outputs 0 within the same cycle, no valid.
// - n change mid-window 3->1 -> current window judged against 8; next against 2.

Source files
------------

// File: rtl/freq_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : freq_lock_monitor
// Brief    : Measures each InFreq period in RefClk cycles, counts OutFreq
//            rising edges per period and flags lock at 2**n +/- TOL edges.
// Revision : 1.0
// ============================================================================
module freq_lock_monitor #(
  parameter int CNT_W = 16,
  parameter int TOL   = 1
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             enable,
  input  logic             InFreq,
  input  logic             OutFreq,
  input  logic [2:0]       n,
  output logic [CNT_W-1:0] in_period,
  output logic [8:0]       out_edges,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;
  localparam logic [1:0] S_EVAL = 2'd3;

  localparam logic [CNT_W-1:0] C_PERIOD_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_PERIOD_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] C_PERIOD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [8:0]       C_EDGE_MAX    = 9'd511;
  localparam logic [9:0]       C_TOL         = 10'(TOL);

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [8:0]       edge_cnt_q,   edge_cnt_d;
  logic [2:0]       n_lat_q,      n_lat_d;
  logic [2:0]       in_sync_q,    in_sync_d;
  logic [2:0]       out_sync_q,   out_sync_d;
  logic [CNT_W-1:0] in_period_q,  in_period_d;
  logic [8:0]       out_edges_q,  out_edges_d;
  logic             valid_q,      valid_d;
  logic             locked_q,     locked_d;
  logic             timeout_q,    timeout_d;

  logic              w_in_pulse;
  logic              w_out_pulse;
  logic [8:0]        w_edge_inc;
  logic [CNT_W-1:0]  w_period_inc;
  logic [9:0]        w_expected;
  logic signed [9:0] w_diff;
  logic [9:0]        w_abs_diff;
  logic              w_in_tol;

  // Bits [1:0] form the synchroniser; bit 2 is the delayed copy for edge detect.
  always_comb begin
    in_sync_d  = {in_sync_q[1:0], InFreq};
    out_sync_d = {out_sync_q[1:0], OutFreq};
  end

  assign w_in_pulse  = in_sync_q[1]  & ~in_sync_q[2];
  assign w_out_pulse = out_sync_q[1] & ~out_sync_q[2];

  assign w_edge_inc   = (w_out_pulse && (edge_cnt_q != C_EDGE_MAX)) ?
                        edge_cnt_q + 9'd1 : edge_cnt_q;
  assign w_period_inc = (period_cnt_q != C_PERIOD_MAX) ?
                        period_cnt_q + C_PERIOD_ONE : period_cnt_q;

  assign w_expected = 10'd1 << n_lat_q;
  assign w_diff     = $signed({1'b0, w_edge_inc}) - $signed(w_expected);
  assign w_abs_diff = w_diff[9] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_in_tol   = (w_abs_diff <= C_TOL);

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    n_lat_d      = n_lat_q;
    in_period_d  = in_period_q;
    out_edges_d  = out_edges_q;
    locked_d     = locked_q;
    timeout_d    = timeout_q;
    valid_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        period_cnt_d = '0;
        edge_cnt_d   = '0;
        if (enable) begin
          state_d = S_ARM;
        end
      end

      S_ARM: begin
        period_cnt_d = '0;
        edge_cnt_d   = '0;
        if (!enable) begin
          state_d = S_IDLE;
        end else if (w_in_pulse) begin
          state_d      = S_MEAS;
          period_cnt_d = C_PERIOD_ONE;
          n_lat_d      = n;
        end
      end

      S_MEAS: begin
        if (!enable) begin
          state_d      = S_IDLE;
          period_cnt_d = '0;
          edge_cnt_d   = '0;
        end else if (w_in_pulse || (period_cnt_q == C_PERIOD_LAST)) begin
          // A coincident OutFreq edge closes with this window; the next opens empty.
          state_d      = S_EVAL;
          valid_d      = 1'b1;
          timeout_d    = !w_in_pulse;
          in_period_d  = w_in_pulse ? period_cnt_q : C_PERIOD_MAX;
          out_edges_d  = w_edge_inc;
          locked_d     = w_in_pulse && w_in_tol;
          period_cnt_d = C_PERIOD_ONE;
          edge_cnt_d   = '0;
          n_lat_d      = n;
        end else begin
          period_cnt_d = w_period_inc;
          edge_cnt_d   = w_edge_inc;
        end
      end

      S_EVAL: begin
        // The window reopened on the closing edge, so this cycle already counts.
        if (!enable) begin
          state_d      = S_IDLE;
          period_cnt_d = '0;
          edge_cnt_d   = '0;
        end else if (timeout_q) begin
          state_d      = S_ARM;
          period_cnt_d = '0;
          edge_cnt_d   = '0;
        end else begin
          state_d      = S_MEAS;
          period_cnt_d = w_period_inc;
          edge_cnt_d   = w_edge_inc;
        end
      end

      default: begin
        state_d      = S_IDLE;
        period_cnt_d = '0;
        edge_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      period_cnt_q <= '0;
      edge_cnt_q   <= '0;
      n_lat_q      <= '0;
      in_sync_q    <= '0;
      out_sync_q   <= '0;
      in_period_q  <= '0;
      out_edges_q  <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      n_lat_q      <= n_lat_d;
      in_sync_q    <= in_sync_d;
      out_sync_q   <= out_sync_d;
      in_period_q  <= in_period_d;
      out_edges_q  <= out_edges_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
    end
  end

  assign in_period = in_period_q;
  assign out_edges = out_edges_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_lock_monitor
// Brief    : Directed bench for freq_lock_monitor with hand-computed windows.
// Revision : 1.0
// ============================================================================
module tb_freq_lock_monitor;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        en8;
  logic        InFreq;
  logic        OutFreq;
  logic [2:0]  n;

  logic [15:0] in_period;
  logic [8:0]  out_edges;
  logic        valid, locked, timeout;

  logic [7:0]  in_period8;
  logic [8:0]  out_edges8;
  logic        valid8, locked8, timeout8;

  int n_checks = 0;
  int n_errors = 0;

  int in_per  = 1000;
  int out_per = 125;
  bit gen_en  = 1'b0;
  int cin     = 0;
  int cout    = 0;

  freq_lock_monitor #(.CNT_W(16), .TOL(1)) dut (
    .RefClk(clk), .rst(rst), .enable(enable), .InFreq(InFreq), .OutFreq(OutFreq),
    .n(n), .in_period(in_period), .out_edges(out_edges), .valid(valid),
    .locked(locked), .timeout(timeout)
  );

  freq_lock_monitor #(.CNT_W(8), .TOL(1)) dut8 (
    .RefClk(clk), .rst(rst), .enable(en8), .InFreq(InFreq), .OutFreq(OutFreq),
    .n(n), .in_period(in_period8), .out_edges(out_edges8), .valid(valid8),
    .locked(locked8), .timeout(timeout8)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Square-wave sources, both rising on the first enabled cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_en) begin
        InFreq  = (cin < in_per / 2);
        OutFreq = (cout < out_per / 2);
        cin  = (cin + 1) % in_per;
        cout = (cout + 1) % out_per;
      end else begin
        cin  = 0;
        cout = 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input bit sel8, input int budget, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if ((sel8 ? valid8 : valid) === 1'b1) return;
    end
    cycles = -1;
    check_val("valid_seen", sel8 ? valid8 : valid, 1);
  endtask

  task automatic start_run(input int ip, input int op, input logic [2:0] nn);
    enable  = 1'b0;
    gen_en  = 1'b0;
    InFreq  = 1'b0;
    OutFreq = 1'b0;
    repeat (8) @(negedge clk);
    in_per  = ip;
    out_per = op;
    n       = nn;
    enable  = 1'b1;
    repeat (4) @(negedge clk);
    gen_en  = 1'b1;
  endtask

  int cyc;
  int vcnt;

  initial begin
    rst = 1'b1; enable = 1'b0; en8 = 1'b0; InFreq = 1'b0; OutFreq = 1'b0; n = 3'd3;
    repeat (3) @(negedge clk);
    check_val("rst_in_period", in_period, 0);
    check_val("rst_out_edges", out_edges, 0);
    check_val("rst_valid",     valid,     0);
    check_val("rst_locked",    locked,    0);
    check_val("rst_timeout",   timeout,   0);
    rst = 1'b0;

    // 1000-cycle windows, 8 edges, n=3
    start_run(1000, 125, 3'd3);
    wait_valid(0, 2000, cyc);
    check_val("w1_out_edges", out_edges, 8);
    wait_valid(0, 1100, cyc);
    check_val("w2_spacing",   cyc,       1000);
    check_val("w2_in_period", in_period, 1000);
    check_val("w2_out_edges", out_edges, 8);
    check_val("w2_locked",    locked,    1);
    check_val("w2_timeout",   timeout,   0);
    @(negedge clk);
    check_val("valid_one_cycle", valid, 0);
    wait_valid(0, 1100, cyc);
    check_val("w3_in_period", in_period, 1000);
    check_val("w3_out_edges", out_edges, 8);
    check_val("w3_locked",    locked,    1);

    // Tolerance: 9 edges still locks, 10 does not
    start_run(1000, 111, 3'd3);
    wait_valid(0, 2000, cyc);
    check_val("tol9_out_edges", out_edges, 9);
    check_val("tol9_locked",    locked,    1);
    start_run(1000, 100, 3'd3);
    wait_valid(0, 2000, cyc);
    check_val("tol10_out_edges", out_edges, 10);
    check_val("tol10_locked",    locked,    0);
    check_val("tol10_in_period", in_period, 1000);

    // Coincident edges: each window gets exactly 4
    start_run(400, 100, 3'd2);
    wait_valid(0, 1000, cyc);
    check_val("coin1_out_edges", out_edges, 4);
    check_val("coin1_locked",    locked,    1);
    wait_valid(0, 500, cyc);
    check_val("coin2_out_edges", out_edges, 4);
    check_val("coin2_in_period", in_period, 400);

    // n changes 3->1 mid-window; 2 edges per window
    start_run(1000, 500, 3'd3);
    wait_valid(0, 2000, cyc);
    check_val("nchg1_locked", locked, 0);
    repeat (500) @(negedge clk);
    n = 3'd1;
    wait_valid(0, 1100, cyc);
    check_val("nchg2_out_edges", out_edges, 2);
    check_val("nchg2_locked",    locked,    0);
    wait_valid(0, 1100, cyc);
    check_val("nchg3_locked",    locked,    1);

    // Abort mid-window
    start_run(1000, 125, 3'd3);
    wait_valid(0, 2000, cyc);
    repeat (300) @(negedge clk);
    enable = 1'b0;
    vcnt = 0;
    repeat (1500) begin
      @(negedge clk);
      if (valid === 1'b1) vcnt++;
    end
    check_val("abort_no_valid",  vcnt,      0);
    check_val("abort_in_period", in_period, 1000);
    check_val("abort_out_edges", out_edges, 8);
    check_val("abort_locked",    locked,    1);

    // Async reset mid-window
    enable = 1'b1;
    wait_valid(0, 2500, cyc);
    repeat (300) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("arst_in_period", in_period, 0);
    check_val("arst_out_edges", out_edges, 0);
    check_val("arst_locked",    locked,    0);
    check_val("arst_valid",     valid,     0);
    vcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (valid === 1'b1) vcnt++;
    end
    check_val("arst_no_valid", vcnt, 0);
    rst = 1'b0;

    // Timeout on the 8-bit instance
    enable = 1'b0; gen_en = 1'b0; InFreq = 1'b0; OutFreq = 1'b0; n = 3'd2; en8 = 1'b1;
    repeat (8) @(negedge clk);
    InFreq = 1'b1;
    repeat (4) @(negedge clk);
    InFreq = 1'b0;
    wait_valid(1, 400, cyc);
    check_val("to_timeout",   timeout8,   1);
    check_val("to_locked",    locked8,    0);
    check_val("to_in_period", in_period8, 255);
    check_val("to_out_edges", out_edges8, 0);
    repeat (20) @(negedge clk);
    InFreq = 1'b1;
    repeat (3) @(negedge clk);
    InFreq = 1'b0;
    repeat (97) @(negedge clk);
    InFreq = 1'b1;
    wait_valid(1, 200, cyc);
    check_val("rearm_in_period", in_period8, 100);
    check_val("rearm_timeout",   timeout8,   0);
    InFreq = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
